seq_alu: RTL and testbench

- Parametrised, multi-cycle successor to the single-cycle CPU's combinational ALU.
- Supports AND/OR/ADD/SUB in one cycle and an iterative shift-add MUL that yields a full 2*WIDTH-bit product.
- Adds a start/valid/busy handshake, a true 1-bit zero flag and a signed-overflow flag.
- Sits in the EX stage of the multi-cycle CPU; the control unit stalls on busy_o.

---
 rtl/seq_alu_pkg.sv | 27 ++
 rtl/seq_alu_if.sv | 25 ++
 rtl/seq_alu_mul_iter.sv | 50 +++++
 rtl/seq_alu.sv | 116 +++++++++++
 tb/tb_seq_alu.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential ALU: op codes, FSM states and flag helpers.
// The ALU-control unit imports the same op codes so both sides agree on encoding.
package seq_alu_pkg;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_MUL = 3'b011,
    OP_SUB = 3'b110
  } alu_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_e;

  // Signed overflow from the sign bits of the operands and the wrapped result.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

  function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
    return (a_msb != b_msb) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Request/response bundle between the EX-stage control and the sequential ALU.
interface seq_alu_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic [WIDTH-1:0] data1_i;
  logic [WIDTH-1:0] data2_i;
  logic [2:0]       ALUCtrl_i;
  logic [WIDTH-1:0] data_o;
  logic [WIDTH-1:0] data_hi_o;
  logic             Zero_o;
  logic             ovf_o;
  logic             valid_o;
  logic             busy_o;

  modport master (
    output start_i, data1_i, data2_i, ALUCtrl_i,
    input  data_o, data_hi_o, Zero_o, ovf_o, valid_o, busy_o
  );

  modport slave (
    input  start_i, data1_i, data2_i, ALUCtrl_i,
    output data_o, data_hi_o, Zero_o, ovf_o, valid_o, busy_o
  );
endinterface

// File: rtl/seq_alu_mul_iter.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per step, WIDTH steps.
// product_next is the accumulator value the current step will write, so the caller can register it on the last step.
module seq_alu_mul_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   mcand_in,
  input  logic [WIDTH-1:0]   mplier_in,
  output logic               done,
  output logic [2*WIDTH-1:0] product_next
);

  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH:0]     upper_sum;

  // The carry out of the upper-half add becomes the new MSB after the right shift.
  always_comb begin
    upper_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
    product_next = {upper_sum, acc[WIDTH-1:1]};
  end

  assign done = (cnt == CNT_W'(WIDTH - 1));

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= mcand_in;
      mplier <= mplier_in;
      cnt    <= '0;
    end else if (step) begin
      acc    <= product_next;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle EX-stage ALU: single-cycle AND/OR/ADD/SUB, WIDTH-cycle unsigned MUL.
// Result registers only change on a completion, so partial products never reach the outputs.
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic     clk_i,
  input  logic     rst_i,
  seq_alu_if.slave bus
);
  import seq_alu_pkg::*;

  state_e             state;
  state_e             state_next;
  logic               load;
  logic               step;
  logic               upd;
  logic [WIDTH-1:0]   lo_next;
  logic [WIDTH-1:0]   hi_next;
  logic               ovf_next;
  logic               mul_done;
  logic [2*WIDTH-1:0] product_next;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [WIDTH-1:0]   sum;
  logic [WIDTH-1:0]   diff;

  assign a    = bus.data1_i;
  assign b    = bus.data2_i;
  assign sum  = a + b;
  assign diff = a - b;

  seq_alu_mul_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_mul (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .load         (load),
    .step         (step),
    .mcand_in     (a),
    .mplier_in    (b),
    .done         (mul_done),
    .product_next (product_next)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) state <= S_IDLE;
    else        state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    upd        = 1'b0;
    lo_next    = '0;
    hi_next    = '0;
    ovf_next   = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start_i) begin
          upd = 1'b1;
          case (bus.ALUCtrl_i)
            OP_AND: lo_next = a & b;
            OP_OR:  lo_next = a | b;
            OP_ADD: begin
              lo_next  = sum;
              ovf_next = add_ovf(a[WIDTH-1], b[WIDTH-1], sum[WIDTH-1]);
            end
            OP_SUB: begin
              lo_next  = diff;
              ovf_next = sub_ovf(a[WIDTH-1], b[WIDTH-1], diff[WIDTH-1]);
            end
            OP_MUL: begin
              upd        = 1'b0;
              load       = 1'b1;
              state_next = S_MUL;
            end
            default: ;  // undefined op completes with an all-zero result
          endcase
        end
      end
      S_MUL: begin
        step = 1'b1;
        if (mul_done) begin
          upd                = 1'b1;
          {hi_next, lo_next} = product_next;
          state_next         = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      bus.data_o    <= '0;
      bus.data_hi_o <= '0;
      bus.Zero_o    <= 1'b0;
      bus.ovf_o     <= 1'b0;
      bus.valid_o   <= 1'b0;
    end else begin
      bus.valid_o <= upd;
      if (upd) begin
        bus.data_o    <= lo_next;
        bus.data_hi_o <= hi_next;
        bus.Zero_o    <= (lo_next == '0);
        bus.ovf_o     <= ovf_next;
      end
    end
  end

  assign bus.busy_o = (state == S_MUL);

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: stimulus pushes expected results, per-width monitors pop on valid_o.
module tb_seq_alu;
  import seq_alu_pkg::*;

  typedef struct {
    logic [63:0] lo;
    logic [63:0] hi;
    logic        zero;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;
  exp_t q32[$];
  exp_t q8[$];
  exp_t e32;
  exp_t e8;

  always #5 clk = ~clk;

  seq_alu_if #(.WIDTH(32)) bus32 ();
  seq_alu_if #(.WIDTH(8))  bus8 ();

  seq_alu #(.WIDTH(32)) u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus32)
  );

  seq_alu #(.WIDTH(8)) u_dut8 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus8)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic push32(input logic [31:0] lo, input logic [31:0] hi, input logic zero, input logic ovf);
    q32.push_back('{lo: 64'(lo), hi: 64'(hi), zero: zero, ovf: ovf});
  endtask

  task automatic send32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus32.start_i   = 1'b1;
    bus32.ALUCtrl_i = op;
    bus32.data1_i   = a;
    bus32.data2_i   = b;
    @(posedge clk); #1;
    bus32.start_i   = 1'b0;
    bus32.data1_i   = 32'hDEAD_BEEF;  // operands may change after acceptance
    bus32.data2_i   = 32'h0BAD_F00D;
  endtask

  task automatic send8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    bus8.start_i   = 1'b1;
    bus8.ALUCtrl_i = op;
    bus8.data1_i   = a;
    bus8.data2_i   = b;
    @(posedge clk); #1;
    bus8.start_i   = 1'b0;
    bus8.data1_i   = 8'h5A;
    bus8.data2_i   = 8'hA5;
  endtask

  task automatic wait_idle32(input int max_cycles);
    int n = 0;
    while (bus32.busy_o !== 1'b0 && n < max_cycles) begin
      @(posedge clk); #1;
      n++;
    end
    check("w32 busy drop within budget", 64'(bus32.busy_o), 64'd0);
  endtask

  task automatic wait_idle8(input int max_cycles);
    int n = 0;
    while (bus8.busy_o !== 1'b0 && n < max_cycles) begin
      @(posedge clk); #1;
      n++;
    end
    check("w8 busy drop within budget", 64'(bus8.busy_o), 64'd0);
  endtask

  always @(negedge clk) begin
    if (bus32.valid_o === 1'b1) begin
      if (q32.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL w32 unexpected valid: data_o=%0h data_hi_o=%0h, required no valid", bus32.data_o, bus32.data_hi_o);
      end else begin
        e32 = q32.pop_front();
        check("w32 data_o", 64'(bus32.data_o), e32.lo);
        check("w32 data_hi_o", 64'(bus32.data_hi_o), e32.hi);
        check("w32 Zero_o", 64'(bus32.Zero_o), 64'(e32.zero));
        check("w32 ovf_o", 64'(bus32.ovf_o), 64'(e32.ovf));
      end
    end
  end

  always @(negedge clk) begin
    if (bus8.valid_o === 1'b1) begin
      if (q8.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL w8 unexpected valid: data_o=%0h data_hi_o=%0h, required no valid", bus8.data_o, bus8.data_hi_o);
      end else begin
        e8 = q8.pop_front();
        check("w8 data_o", 64'(bus8.data_o), e8.lo);
        check("w8 data_hi_o", 64'(bus8.data_hi_o), e8.hi);
        check("w8 Zero_o", 64'(bus8.Zero_o), 64'(e8.zero));
        check("w8 ovf_o", 64'(bus8.ovf_o), 64'(e8.ovf));
      end
    end
  end

  initial begin
    bus32.start_i = 1'b0; bus32.ALUCtrl_i = '0; bus32.data1_i = '0; bus32.data2_i = '0;
    bus8.start_i  = 1'b0; bus8.ALUCtrl_i  = '0; bus8.data1_i  = '0; bus8.data2_i  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset data_o", 64'(bus32.data_o), 64'd0);
    check("reset valid_o", 64'(bus32.valid_o), 64'd0);
    check("reset busy_o", 64'(bus32.busy_o), 64'd0);
    check("reset Zero_o", 64'(bus32.Zero_o), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // ADD signed overflow, latency 1
    push32(32'h8000_0000, 32'h0, 1'b0, 1'b1);
    send32(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
    check("add latency valid_o", 64'(bus32.valid_o), 64'd1);
    check("add busy_o", 64'(bus32.busy_o), 64'd0);

    // SUB overflow, ADD wrap without signed overflow
    push32(32'h7FFF_FFFF, 32'h0, 1'b0, 1'b1);
    send32(OP_SUB, 32'h8000_0000, 32'h0000_0001);
    push32(32'h0000_0000, 32'h0, 1'b1, 1'b0);
    send32(OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001);

    // back-to-back SUB then AND
    push32(32'h0, 32'h0, 1'b1, 1'b0);
    send32(OP_SUB, 32'd5, 32'd5);
    check("b2b first valid_o", 64'(bus32.valid_o), 64'd1);
    push32(32'h00F0_00F0, 32'h0, 1'b0, 1'b0);
    send32(OP_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    check("b2b second valid_o", 64'(bus32.valid_o), 64'd1);

    // full-width MUL: busy for 32 cycles, outputs frozen meanwhile
    push32(32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0);
    send32(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int i = 0; i < 32; i++) begin
      check("mul busy_o during op", 64'(bus32.busy_o), 64'd1);
      check("mul data_o held", 64'(bus32.data_o), 64'h00F0_00F0);
      @(posedge clk); #1;
    end
    check("mul done busy_o", 64'(bus32.busy_o), 64'd0);
    check("mul done valid_o", 64'(bus32.valid_o), 64'd1);
    @(posedge clk); #1;
    check("mul valid one cycle", 64'(bus32.valid_o), 64'd0);

    // reset mid-MUL abandons the op
    send32(OP_MUL, 32'd3, 32'd3);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("midmul reset data_o", 64'(bus32.data_o), 64'd0);
    check("midmul reset data_hi_o", 64'(bus32.data_hi_o), 64'd0);
    check("midmul reset busy_o", 64'(bus32.busy_o), 64'd0);
    check("midmul reset valid_o", 64'(bus32.valid_o), 64'd0);
    rst = 1'b1;
    push32(32'd5, 32'h0, 1'b0, 1'b0);
    send32(OP_ADD, 32'd2, 32'd3);
    check("post-reset add valid_o", 64'(bus32.valid_o), 64'd1);
    repeat (30) @(posedge clk);
    #1;

    // MUL by zero with an OR request ignored while busy
    push32(32'h0, 32'h0, 1'b1, 1'b0);
    send32(OP_MUL, 32'h1234_5678, 32'h0);
    repeat (4) @(posedge clk);
    #1;
    bus32.start_i = 1'b1; bus32.ALUCtrl_i = OP_OR; bus32.data1_i = 32'd1; bus32.data2_i = 32'd2;
    repeat (3) @(posedge clk);
    #1;
    bus32.start_i = 1'b0;
    wait_idle32(40);
    check("mul0 valid at completion", 64'(bus32.valid_o), 64'd1);

    // undefined op codes
    push32(32'h0, 32'h0, 1'b1, 1'b0);
    send32(3'b111, 32'd5, 32'd7);
    push32(32'h0, 32'h0, 1'b1, 1'b0);
    send32(3'b100, 32'd3, 32'd3);

    // WIDTH=8 instance
    q8.push_back('{lo: 64'h80, hi: 64'h0, zero: 1'b0, ovf: 1'b1});
    send8(OP_ADD, 8'h7F, 8'h01);
    q8.push_back('{lo: 64'hFE, hi: 64'h01, zero: 1'b0, ovf: 1'b0});
    send8(OP_MUL, 8'hFF, 8'h02);
    for (int i = 0; i < 8; i++) begin
      check("w8 mul busy_o during op", 64'(bus8.busy_o), 64'd1);
      @(posedge clk); #1;
    end
    wait_idle8(4);
    check("w8 mul valid at k+8", 64'(bus8.valid_o), 64'd1);

    repeat (3) @(posedge clk);
    #1;
    check("w32 scoreboard drained", 64'(q32.size()), 64'd0);
    check("w8 scoreboard drained", 64'(q8.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
